// File: rtl/ysyx_22050039_idu.sv
// Decode/issue stage: decodes RV64 instructions, samples register operands at accept,
// and queues operand bundles for EXU behind a RAW scoreboard.
module ysyx_22050039_idu #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    input  logic [XLEN-1:0] rs1_data,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_func,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output logic [XLEN-1:0] out_store,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        FN_ADDI    = 3'd0,
        FN_JALR    = 3'd1,
        FN_AUIPC   = 3'd2,
        FN_LUI     = 3'd3,
        FN_SD      = 3'd4,
        FN_JAL     = 3'd5,
        FN_EBREAK  = 3'd6,
        FN_INVALID = 3'd7
    } func_e;

    typedef struct packed {
        logic [2:0]      func;
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic [XLEN-1:0] store;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            wen;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        busy_q, busy_d;
    logic               halted_q, halted_d;

    entry_t             dec;
    logic               uses_rs1, uses_rs2, writes_rd;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [XLEN-1:0]    imm_i, imm_s, imm_u, imm_j;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    assign imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_u = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                    in_inst[20], in_inst[30:21], 1'b0};

    always_comb begin
        dec       = '0;
        dec.func  = FN_INVALID;
        dec.pc    = in_pc;
        dec.rd    = in_inst[11:7];
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        if (in_inst == 32'h0010_0073) begin
            dec.func = FN_EBREAK;
        end else begin
            case (opcode)
                7'b0010011: if (funct3 == 3'b000) begin
                    dec.func = FN_ADDI;  dec.src1 = rs1_data; dec.src2 = imm_i;
                    uses_rs1 = 1'b1;     writes_rd = 1'b1;
                end
                7'b1100111: begin
                    dec.func = FN_JALR;  dec.src1 = rs1_data; dec.src2 = imm_i;
                    uses_rs1 = 1'b1;     writes_rd = 1'b1;
                end
                7'b0010111: begin
                    dec.func = FN_AUIPC; dec.src1 = imm_u; writes_rd = 1'b1;
                end
                7'b0110111: begin
                    dec.func = FN_LUI;   dec.src1 = imm_u; writes_rd = 1'b1;
                end
                7'b0100011: if (funct3 == 3'b011) begin
                    dec.func  = FN_SD;   dec.src1 = rs1_data; dec.src2 = imm_s;
                    dec.store = rs2_data;
                    uses_rs1  = 1'b1;    uses_rs2 = 1'b1;
                end
                7'b1101111: begin
                    dec.func = FN_JAL;   dec.src1 = imm_j; writes_rd = 1'b1;
                end
                default: ;
            endcase
        end
        dec.wen = writes_rd && (dec.rd != 5'd0);
    end

    // An in-flight producer is either still queued (FIFO match) or issued but not written back.
    logic [DEPTH-1:0] entry_valid, hit1, hit2;
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
            logic [PTR_W-1:0] offset;
            assign offset          = PTR_W'(gi) - rd_ptr_q;
            assign entry_valid[gi] = {1'b0, offset} < count_q;
            assign hit1[gi] = entry_valid[gi] && mem_q[gi].wen && (mem_q[gi].rd == rs1_addr);
            assign hit2[gi] = entry_valid[gi] && mem_q[gi].wen && (mem_q[gi].rd == rs2_addr);
        end
    endgenerate

    logic hazard, full, accept, issue;
    entry_t head;

    assign hazard = (uses_rs1 && (rs1_addr != 5'd0) && (busy_q[rs1_addr] || (|hit1))) ||
                    (uses_rs2 && (rs2_addr != 5'd0) && (busy_q[rs2_addr] || (|hit2)));
    assign full      = (count_q == CNT_W'(DEPTH));
    assign in_ready  = rst && !full && !hazard && !flush && !halted_q;
    assign accept    = in_valid && in_ready;
    assign out_valid = (count_q != '0);
    assign issue     = out_valid && out_ready;
    assign head      = out_valid ? mem_q[rd_ptr_q] : '0;

    assign out_func  = head.func;
    assign out_src1  = head.src1;
    assign out_src2  = head.src2;
    assign out_store = head.store;
    assign out_pc    = head.pc;
    assign out_rd    = head.rd;
    assign out_wen   = head.wen;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q + PTR_W'(issue);
        wr_ptr_d = wr_ptr_q + PTR_W'(accept);
        count_d  = count_q;
        case ({accept, issue})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (accept) mem_d[wr_ptr_q] = dec;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
        // Clear first so a same-cycle issue to the same register keeps it busy.
        busy_d = busy_q;
        if (wb_valid) busy_d[wb_rd] = 1'b0;
        if (issue && head.wen) busy_d[head.rd] = 1'b1;
        busy_d[0] = 1'b0;
        halted_d = halted_q ||
                   (accept && ((dec.func == FN_EBREAK) || (dec.func == FN_INVALID)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    // Payload needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_ysyx_22050039_idu.sv
// Directed bench for ysyx_22050039_idu: decode, backpressure, RAW scoreboard, flush, halt.
module tb_ysyx_22050039_idu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rs1_data, rs2_data;
    logic        out_valid, out_ready;
    logic [2:0]  out_func;
    logic [63:0] out_src1, out_src2, out_store, out_pc;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;

    int checks = 0;
    int errors = 0;

    ysyx_22050039_idu #(.XLEN(64), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_func(out_func),
        .out_src1(out_src1), .out_src2(out_src2), .out_store(out_store), .out_pc(out_pc),
        .out_rd(out_rd), .out_wen(out_wen),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b1; in_inst = 32'hFFD1_0093; in_pc = '0;
        rs1_data = '0; rs2_data = '0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;

        // Reset held two cycles with in_valid high
        step; step; #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_func", 64'(out_func), 64'd0);
        chk("rst_src1", out_src1, 64'd0);
        chk("rst_src2", out_src2, 64'd0);
        chk("rst_store", out_store, 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_rd", 64'(out_rd), 64'd0);
        chk("rst_wen", 64'(out_wen), 64'd0);
        rst = 1'b1; in_valid = 1'b0; #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        // addi x1,x2,-3
        in_valid = 1'b1; in_pc = 64'h100; rs1_data = 64'd10; #1;
        chk("addi_rs1_addr", 64'(rs1_addr), 64'd2);
        chk("addi_rs2_addr", 64'(rs2_addr), 64'd29);
        step; in_valid = 1'b0; rs1_data = '0; #1;
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_func", 64'(out_func), 64'd0);
        chk("addi_src1", out_src1, 64'd10);
        chk("addi_src2", out_src2, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("addi_store", out_store, 64'd0);
        chk("addi_pc", out_pc, 64'h100);
        chk("addi_rd", 64'(out_rd), 64'd1);
        chk("addi_wen", 64'(out_wen), 64'd1);
        out_ready = 1'b1;
        step; out_ready = 1'b0; #1;
        chk("empty_valid", 64'(out_valid), 64'd0);
        chk("empty_src2", out_src2, 64'd0);

        // RAW on x1: addi x2,x1,1
        in_valid = 1'b1; in_inst = 32'h0010_8113; rs1_data = 64'h55; #1;
        chk("raw_busy", 64'(in_ready), 64'd0);
        step; wb_valid = 1'b1; wb_rd = 5'd1; #1;
        chk("raw_wb_same_cycle", 64'(in_ready), 64'd0);
        step; wb_valid = 1'b0; rs1_data = 64'h77; out_ready = 1'b1; #1;
        chk("raw_release", 64'(in_ready), 64'd1);
        step; in_valid = 1'b0; #1;
        chk("raw_valid", 64'(out_valid), 64'd1);
        chk("raw_src1", out_src1, 64'h77);
        chk("raw_src2", out_src2, 64'd1);
        chk("raw_rd", 64'(out_rd), 64'd2);
        step; out_ready = 1'b0; #1;
        chk("raw_issued", 64'(out_valid), 64'd0);

        // Backpressure: addi x0,x0,5 ; addi x3,x0,7 ; lui x5,0x80000
        in_valid = 1'b1; in_inst = 32'h0050_0013; in_pc = 64'h0; #1;
        chk("bp0_in_ready", 64'(in_ready), 64'd1);
        step; in_inst = 32'h0070_0193; in_pc = 64'h4; #1;
        chk("x0_no_stall", 64'(in_ready), 64'd1);
        chk("bp0_pc", out_pc, 64'h0);
        chk("bp0_wen", 64'(out_wen), 64'd0);
        chk("bp0_rd", 64'(out_rd), 64'd0);
        chk("bp0_src2", out_src2, 64'd5);
        step; in_inst = 32'h8000_02B7; in_pc = 64'h8; #1;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step; #1;
        chk("bp1_pc", out_pc, 64'h4);
        chk("bp1_src2", out_src2, 64'd7);
        chk("bp1_rd", 64'(out_rd), 64'd3);
        chk("bp1_wen", 64'(out_wen), 64'd1);
        chk("bp_third_ready", 64'(in_ready), 64'd1);
        step; out_ready = 1'b0; #1;
        chk("lui_func", 64'(out_func), 64'd3);
        chk("lui_src1", out_src1, 64'hFFFF_FFFF_8000_0000);
        chk("lui_pc", out_pc, 64'h8);
        chk("lui_rd", 64'(out_rd), 64'd5);
        in_inst = 32'h0012_8313; in_pc = 64'hC; #1;
        chk("fifo_rd_hazard", 64'(in_ready), 64'd0);
        in_inst = 32'h0000_1397; #1;
        chk("auipc_in_ready", 64'(in_ready), 64'd1);

        // Flush with two queued entries; head (lui x5) issues in the flush cycle
        step; in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1; #1;
        chk("flush_blocks", 64'(in_ready), 64'd0);
        chk("flush_head_pc", out_pc, 64'h8);
        step; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0012_8313; #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("sb_kept_after_flush", 64'(in_ready), 64'd0);
        wb_valid = 1'b1; wb_rd = 5'd5;
        step; wb_valid = 1'b0; rs1_data = 64'h20; #1;
        chk("x5_released", 64'(in_ready), 64'd1);
        step; in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b1; wb_rd = 5'd6; #1;
        chk("x6_src1", out_src1, 64'h20);
        chk("x6_rd", 64'(out_rd), 64'd6);
        step; wb_valid = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0003_0413; #1;
        chk("x6_issued", 64'(out_valid), 64'd0);
        chk("set_wins", 64'(in_ready), 64'd0);

        // sd x4,-8(x1) then jal x1,+8
        in_inst = 32'hFE40_BC23; in_pc = 64'h10; rs1_data = 64'h1000; rs2_data = 64'hABCD; #1;
        chk("sd_in_ready", 64'(in_ready), 64'd1);
        chk("sd_rs2_addr", 64'(rs2_addr), 64'd4);
        step; in_inst = 32'h0080_00EF; in_pc = 64'h20; rs1_data = '0; rs2_data = '0; #1;
        chk("sd_func", 64'(out_func), 64'd4);
        chk("sd_src1", out_src1, 64'h1000);
        chk("sd_src2", out_src2, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("sd_store", out_store, 64'hABCD);
        chk("sd_rd", 64'(out_rd), 64'd24);
        chk("sd_wen", 64'(out_wen), 64'd0);
        chk("jal_in_ready", 64'(in_ready), 64'd1);
        step; in_valid = 1'b0; out_ready = 1'b1; #1;
        chk("sd_still_head", 64'(out_func), 64'd4);
        step; #1;
        chk("jal_func", 64'(out_func), 64'd5);
        chk("jal_src1", out_src1, 64'd8);
        chk("jal_store", out_store, 64'd0);
        chk("jal_rd", 64'(out_rd), 64'd1);
        chk("jal_wen", 64'(out_wen), 64'd1);
        chk("jal_pc", out_pc, 64'h20);

        // jalr x0,4(x4)
        step; in_valid = 1'b1; in_inst = 32'h0042_0067; in_pc = 64'h30; rs1_data = 64'h3000; #1;
        chk("jalr_in_ready", 64'(in_ready), 64'd1);
        chk("jalr_empty", 64'(out_valid), 64'd0);
        step; in_valid = 1'b0; #1;
        chk("jalr_func", 64'(out_func), 64'd1);
        chk("jalr_src1", out_src1, 64'h3000);
        chk("jalr_src2", out_src2, 64'd4);
        chk("jalr_wen", 64'(out_wen), 64'd0);

        // ebreak halts acceptance
        step; in_valid = 1'b1; in_inst = 32'h0010_0073; in_pc = 64'h40; #1;
        chk("ebreak_in_ready", 64'(in_ready), 64'd1);
        step; in_inst = 32'hFFFF_FFFF; #1;
        chk("halted", 64'(in_ready), 64'd0);
        chk("ebreak_func", 64'(out_func), 64'd6);
        chk("ebreak_wen", 64'(out_wen), 64'd0);
        chk("ebreak_pc", out_pc, 64'h40);
        step; #1;
        chk("ebreak_issued", 64'(out_valid), 64'd0);
        chk("halted_stays", 64'(in_ready), 64'd0);

        // Reset clears halt; undefined word decodes as Invalid
        out_ready = 1'b0; rst = 1'b0;
        step; rst = 1'b1; #1;
        chk("halt_cleared", 64'(in_ready), 64'd1);
        step; in_valid = 1'b0; #1;
        chk("inv_valid", 64'(out_valid), 64'd1);
        chk("inv_func", 64'(out_func), 64'd7);
        chk("inv_wen", 64'(out_wen), 64'd0);
        chk("inv_rd", 64'(out_rd), 64'd31);
        chk("inv_src1", out_src1, 64'd0);
        chk("inv_halts", 64'(in_ready), 64'd0);

        // Reset mid-operation drops the queued entry and the scoreboard
        rst = 1'b0;
        step; rst = 1'b1; in_valid = 1'b1; in_inst = 32'h0003_0413; #1;
        chk("reset_drops", 64'(out_valid), 64'd0);
        chk("reset_sb_clear", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
